// File: rtl/pmem_loader.sv
// pmem_loader: packs UART bytes into big-endian words, writes them to pmem from address 0,
// holds the CPU until done. Write lands one clock after the 4th byte. No backpressure: a byte can arrive every clock.
module pmem_loader #(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter logic [31:0] END_WORD       = 32'hFFFF_FFFF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic                  timeout_err,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  cpu_hold
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   state_t        state, state_nxt;
   logic [23:0]   shreg;
   logic [1:0]    idx;
   logic [TW-1:0] timer;
   logic [31:0]   word;
   logic          last_byte;
   logic          is_end;
   logic          mem_full;
   logic          tmo_hit;

   // Earlier bytes sit in shreg, so the current byte completes the word combinationally.
   assign word      = {shreg, rx_data};
   assign last_byte = (state == RECV) && rx_valid && (idx == 2'd3);
   assign is_end    = (word == END_WORD);
   assign mem_full  = (state == RECV) && mem_we && (&mem_addr);
   assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (state == RECV) && (idx != 2'd0) &&
                      !rx_valid && (timer == TW'(TIMEOUT_CYCLES - 1));

   assign busy     = (state == RECV);
   assign done     = (state == DONE);
   assign cpu_hold = (state != DONE);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RECV;
         RECV:    if (mem_full || tmo_hit || (last_byte && is_end)) state_nxt = DONE;
         DONE:    if (start) state_nxt = RECV;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
         word_count  <= '0;
         shreg       <= '0;
         idx         <= '0;
         timer       <= '0;
      end else begin
         mem_we <= 1'b0;
         if (state != RECV) begin
            if (start) begin
               mem_addr    <= '0;
               overflow    <= 1'b0;
               timeout_err <= 1'b0;
               word_count  <= '0;
               idx         <= '0;
               timer       <= '0;
            end
         end else if (mem_full) begin
            // Last address just written; a byte arriving this cycle is dropped.
            overflow <= 1'b1;
            idx      <= '0;
         end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            idx         <= '0;
            timer       <= '0;
         end else if (rx_valid) begin
            timer <= '0;
            idx   <= idx + 2'd1;
            shreg <= word[23:0];
            if (last_byte && !is_end) begin
               mem_we    <= 1'b1;
               mem_addr  <= word_count[ADDR_WIDTH-1:0];
               mem_wdata <= word;
               if (word_count != DEPTH) word_count <= word_count + 1'b1;
            end
         end else if (idx != 2'd0) begin
            timer <= timer + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pmem_loader.sv
// Bench for pmem_loader: vector table, hand-written corner sequences, randomized loads vs a word-level model.
`timescale 1ns/1ps
module tb_pmem_loader;

   localparam int AW = 3;
   localparam int TO = 16;

   logic          clock = 1'b0;
   logic          reset, start, rx_valid;
   logic [7:0]    rx_data;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          busy, done, overflow, timeout_err, cpu_hold;
   logic [AW:0]   word_count;

   pmem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .END_WORD(32'hFFFF_FFFF)) u_dut (
      .clock(clock), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
      .overflow(overflow), .timeout_err(timeout_err), .word_count(word_count), .cpu_hold(cpu_hold)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   logic [AW-1:0] got_addr[$];
   logic [31:0]   got_data[$];

   always @(negedge clock) begin
      if (mem_we) begin
         got_addr.push_back(mem_addr);
         got_data.push_back(mem_wdata);
      end
   end

   typedef struct {
      logic          s;
      logic          v;
      logic [7:0]    d;
      logic          we;
      logic [31:0]   wd;
      logic [AW-1:0] ad;
      logic          bz;
      logic          dn;
      logic [AW:0]   cnt;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input logic s, input logic v, input logic [7:0] d);
      start = s; rx_valid = v; rx_data = d;
      @(posedge clock); #1;
      start = 1'b0; rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1'b0, 1'b0, 8'h00);
      tick(1'b0, 1'b0, 8'h00);
      reset = 1'b0;
   endtask

   task automatic clear_mon();
      got_addr.delete();
      got_data.delete();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".we"},    mem_we,      0);
      chk({tag, ".addr"},  mem_addr,    0);
      chk({tag, ".wdata"}, mem_wdata,   0);
      chk({tag, ".busy"},  busy,        0);
      chk({tag, ".done"},  done,        0);
      chk({tag, ".ovf"},   overflow,    0);
      chk({tag, ".tmo"},   timeout_err, 0);
      chk({tag, ".cnt"},   word_count,  0);
      chk({tag, ".hold"},  cpu_hold,    1);
   endtask

   function automatic int pick_gap();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return TO + $urandom_range(0, 3);
      if (r == 1) return TO - 1;
      return $urandom_range(0, 2);
   endfunction

   task automatic run_random(input int trial);
      logic [7:0]    bq[$];
      int            gq[$];
      logic [AW-1:0] ea[$];
      logic [31:0]   ed[$];
      logic [31:0]   w;
      int            nw, nextra, part, n;
      bit            term, fin, eovf, etmo;
      nw = $urandom_range(1, 11);
      for (int i = 0; i < nw; i++) begin
         term = ($urandom_range(0, 7) == 0);
         for (int b = 0; b < 4; b++) begin
            bq.push_back(term ? 8'hFF : 8'($urandom_range(0, 255)));
            gq.push_back(pick_gap());
         end
      end
      nextra = $urandom_range(0, 3);
      for (int i = 0; i < nextra; i++) begin
         bq.push_back(8'($urandom_range(0, 255)));
         gq.push_back(pick_gap());
      end
      // Word-level expectation: terminator, memory full, or idle gap inside a word ends the load.
      w = 0; part = 0; n = 0; fin = 0; eovf = 0; etmo = 0;
      for (int i = 0; i < bq.size() && !fin; i++) begin
         if (part != 0 && gq[i] >= TO) begin
            etmo = 1; fin = 1;
         end else begin
            w = {w[23:0], bq[i]};
            part++;
            if (part == 4) begin
               part = 0;
               if (w == 32'hFFFF_FFFF) fin = 1;
               else begin
                  ea.push_back(AW'(n));
                  ed.push_back(w);
                  n++;
                  if (n == (1 << AW)) begin eovf = 1; fin = 1; end
               end
            end
         end
      end
      if (!fin && part != 0) begin etmo = 1; fin = 1; end

      do_reset();
      clear_mon();
      tick(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < bq.size(); i++) begin
         repeat (gq[i]) tick(1'b0, 1'b0, 8'h00);
         tick(1'b0, 1'b1, bq[i]);
      end
      repeat (TO + 4) tick(1'b0, 1'b0, 8'h00);

      chk($sformatf("rnd%0d.nwr", trial), got_addr.size(), ea.size());
      for (int i = 0; i < ea.size() && i < got_addr.size(); i++) begin
         chk($sformatf("rnd%0d.addr%0d", trial, i), got_addr[i], ea[i]);
         chk($sformatf("rnd%0d.data%0d", trial, i), got_data[i], ed[i]);
      end
      chk($sformatf("rnd%0d.done", trial), done,        fin);
      chk($sformatf("rnd%0d.busy", trial), busy,        !fin);
      chk($sformatf("rnd%0d.hold", trial), cpu_hold,    !fin);
      chk($sformatf("rnd%0d.ovf",  trial), overflow,    eovf);
      chk($sformatf("rnd%0d.tmo",  trial), timeout_err, etmo);
      chk($sformatf("rnd%0d.cnt",  trial), word_count,  n);
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ew;
      reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

      //        s     v     d      we    wdata          ad    bz    dn    cnt
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd0};
      tbl[1]  = '{1'b0, 1'b1, 8'h12, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd0};
      tbl[2]  = '{1'b0, 1'b1, 8'h34, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd0};
      tbl[3]  = '{1'b0, 1'b1, 8'h56, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd0};
      tbl[4]  = '{1'b0, 1'b1, 8'h78, 1'b1, 32'h12345678, 3'd0, 1'b1, 1'b0, 4'd1};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd1};
      tbl[6]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd1};
      tbl[7]  = '{1'b0, 1'b1, 8'hBB, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd1};
      tbl[8]  = '{1'b0, 1'b1, 8'hCC, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd1};
      tbl[9]  = '{1'b0, 1'b1, 8'hDD, 1'b1, 32'hAABBCCDD, 3'd1, 1'b1, 1'b0, 4'd2};
      tbl[10] = '{1'b0, 1'b1, 8'hFF, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd2};
      tbl[11] = '{1'b0, 1'b1, 8'hFF, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd2};
      tbl[12] = '{1'b0, 1'b1, 8'hFF, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd2};
      tbl[13] = '{1'b0, 1'b1, 8'hFF, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 4'd2};
      tbl[14] = '{1'b0, 1'b1, 8'h55, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 4'd2};
      tbl[15] = '{1'b1, 1'b1, 8'h11, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd0};
      tbl[16] = '{1'b0, 1'b1, 8'h22, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd0};
      tbl[17] = '{1'b0, 1'b1, 8'h33, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd0};
      tbl[18] = '{1'b0, 1'b1, 8'h44, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 4'd0};
      tbl[19] = '{1'b0, 1'b1, 8'h55, 1'b1, 32'h22334455, 3'd0, 1'b1, 1'b0, 4'd1};

      do_reset();
      chk_reset_vals("rst");

      for (int i = 0; i < 20; i++) begin
         tick(tbl[i].s, tbl[i].v, tbl[i].d);
         chk($sformatf("vec%0d.we", i),   mem_we,      tbl[i].we);
         chk($sformatf("vec%0d.busy", i), busy,        tbl[i].bz);
         chk($sformatf("vec%0d.done", i), done,        tbl[i].dn);
         chk($sformatf("vec%0d.hold", i), cpu_hold,    !tbl[i].dn);
         chk($sformatf("vec%0d.cnt", i),  word_count,  tbl[i].cnt);
         chk($sformatf("vec%0d.ovf", i),  overflow,    0);
         chk($sformatf("vec%0d.tmo", i),  timeout_err, 0);
         if (tbl[i].we) begin
            chk($sformatf("vec%0d.addr", i),  mem_addr,  tbl[i].ad);
            chk($sformatf("vec%0d.wdata", i), mem_wdata, tbl[i].wd);
         end
      end

      // Overflow: 9 words into an 8-word memory, no terminator.
      do_reset();
      clear_mon();
      tick(1'b1, 1'b0, 8'h00);
      for (int w = 0; w < 9; w++) begin
         for (int b = 0; b < 4; b++) tick(1'b0, 1'b1, 8'(8'h10 * w + b));
         if (w == 7) begin
            chk("ovf.last_we",   mem_we,   1);
            chk("ovf.last_addr", mem_addr, 7);
            chk("ovf.pre_flag",  overflow, 0);
            tick(1'b0, 1'b0, 8'h00);
            chk("ovf.flag", overflow,   1);
            chk("ovf.done", done,       1);
            chk("ovf.busy", busy,       0);
            chk("ovf.hold", cpu_hold,   0);
            chk("ovf.cnt",  word_count, 8);
         end
      end
      repeat (3) tick(1'b0, 1'b0, 8'h00);
      chk("ovf.nwr", got_addr.size(), 8);
      for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
         ew = {8'(8'h10 * i), 8'(8'h10 * i + 1), 8'(8'h10 * i + 2), 8'(8'h10 * i + 3)};
         chk($sformatf("ovf.addr%0d", i), got_addr[i], i);
         chk($sformatf("ovf.data%0d", i), got_data[i], ew);
      end

      // Timeout: two bytes then idle; fires on the 16th idle clock.
      do_reset();
      clear_mon();
      tick(1'b1, 1'b0, 8'h00);
      tick(1'b0, 1'b1, 8'h01);
      tick(1'b0, 1'b1, 8'h02);
      repeat (TO - 1) tick(1'b0, 1'b0, 8'h00);
      chk("tmo.pre_busy", busy,        1);
      chk("tmo.pre_flag", timeout_err, 0);
      tick(1'b0, 1'b0, 8'h00);
      chk("tmo.flag", timeout_err, 1);
      chk("tmo.done", done,        1);
      chk("tmo.hold", cpu_hold,    0);
      chk("tmo.nwr",  got_addr.size(), 0);

      // Reset mid-word drops the partial word.
      do_reset();
      tick(1'b1, 1'b0, 8'h00);
      tick(1'b0, 1'b1, 8'h9A);
      tick(1'b0, 1'b1, 8'hBC);
      tick(1'b0, 1'b1, 8'hDE);
      reset = 1'b1;
      tick(1'b0, 1'b0, 8'h00);
      reset = 1'b0;
      chk_reset_vals("midrst");
      clear_mon();
      tick(1'b1, 1'b0, 8'h00);
      tick(1'b0, 1'b1, 8'hAB);
      tick(1'b0, 1'b1, 8'hCD);
      tick(1'b0, 1'b1, 8'hEF);
      tick(1'b0, 1'b1, 8'h01);
      tick(1'b0, 1'b0, 8'h00);
      chk("midrst.nwr", got_addr.size(), 1);
      if (got_addr.size() > 0) begin
         chk("midrst.addr", got_addr[0], 0);
         chk("midrst.data", got_data[0], 32'hABCDEF01);
      end

      // Byte plus start during the write cycle: byte kept, start ignored.
      do_reset();
      clear_mon();
      tick(1'b1, 1'b0, 8'h00);
      tick(1'b0, 1'b1, 8'h11);
      tick(1'b0, 1'b1, 8'h22);
      tick(1'b0, 1'b1, 8'h33);
      tick(1'b0, 1'b1, 8'h44);
      chk("wcyc.we", mem_we, 1);
      tick(1'b1, 1'b1, 8'h55);
      chk("wcyc.busy", busy, 1);
      tick(1'b0, 1'b1, 8'h66);
      tick(1'b0, 1'b1, 8'h77);
      tick(1'b0, 1'b1, 8'h88);
      tick(1'b0, 1'b0, 8'h00);
      chk("wcyc.nwr", got_addr.size(), 2);
      chk("wcyc.cnt", word_count, 2);
      if (got_addr.size() > 1) begin
         chk("wcyc.addr1", got_addr[1], 1);
         chk("wcyc.data1", got_data[1], 32'h55667788);
      end

      for (int t = 0; t < 40; t++) run_random(t);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
